// File: rtl/vfx_pkg.sv
// Shared constants and types for the windowed video filter sequencer.
// IMAGE_WIDTH/IMAGE_HEIGHT describe the RGB444 frame geometry; TOTAL_PIXELS
// is the pixel count of one frame and BLUR_DELAY the 5x5 window latency
// (two full lines plus the 3-pixel centre offset), counted in accepted pixels.
package vfx_pkg;

    localparam int IMAGE_WIDTH  = 320;
    localparam int IMAGE_HEIGHT = 240;
    localparam int TOTAL_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int BLUR_DELAY   = 2 * IMAGE_WIDTH + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    // Window latency for an arbitrary line width.
    function automatic int blur_delay(input int width);
        return 2 * width + 3;
    endfunction

endpackage

// File: rtl/blur_frame_sequencer_pixel_counter.sv
// pixel_counter: wrapping up-counter with a registered terminal-count flag.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : advance the count this cycle
//   clr        : restart from zero this cycle; clr together with inc loads 1
//   count      : current count (wraps to 0 after TERMINAL)
//   term       : registered flag, high while count == TERMINAL
module pixel_counter #(
    parameter int CNT_W    = 17,
    parameter int TERMINAL = 76799
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] base;
    logic             term_reg;

    always_comb begin
        base       = clr ? '0 : count_reg;
        count_next = base;
        if (inc) begin
            count_next = (base == TERM_C) ? '0 : base + 1'b1;
        end
    end

    // The flag is computed from the next count so it lines up with count_reg.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            term_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            term_reg  <= (count_next == TERM_C);
        end
    end

    assign count = count_reg;
    assign term  = term_reg;

endmodule

// File: rtl/blur_frame_sequencer.sv
// blur_frame_sequencer: frame-level control for the 5x5 windowed filter.
// Gates the filter shift register, fills its line buffer, drains the last
// DELAY pixels after EOP and produces aligned out_valid/out_sop/out_eop.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/sop/eop    : upstream Avalon-ST framing; in_ready back to upstream
//   out_ready           : downstream ready
//   freq_flag           : blur request, sampled only on an accepted SOP
//   shift_en, flush     : filter shift enable; flush shifts zero pixels in
//   mode_sel            : filter mode latched for the current frame
//   out_valid/sop/eop   : output framing, registered alongside filter data_out
//   frame_err           : one-cycle pulse on a malformed frame
//   busy                : sequencer not idle
module blur_frame_sequencer #(
    parameter int IMAGE_WIDTH  = vfx_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = vfx_pkg::IMAGE_HEIGHT
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_sop,
    input  logic in_eop,
    output logic in_ready,
    input  logic out_ready,
    input  logic freq_flag,
    output logic shift_en,
    output logic flush,
    output logic mode_sel,
    output logic out_valid,
    output logic out_sop,
    output logic out_eop,
    output logic frame_err,
    output logic busy
);

    import vfx_pkg::seq_state_t;
    import vfx_pkg::IDLE;
    import vfx_pkg::FILL;
    import vfx_pkg::RUN;
    import vfx_pkg::DRAIN;
    import vfx_pkg::blur_delay;

    localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int DELAY = blur_delay(IMAGE_WIDTH);
    localparam int CNT_W = $clog2(TOTAL);
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DELAY);

    seq_state_t       state_reg, state_next;
    logic             mode_reg, mode_next;
    logic             overrun_reg, overrun_next;
    logic             frame_err_reg, err_next;
    logic             out_valid_reg, out_sop_reg, out_eop_reg;

    logic             acc, emit, restart, drain_done, in_inc;
    logic [CNT_W-1:0] in_cnt, out_cnt, drain_cnt_unused;
    logic             in_term, out_term, drain_term;

    always_comb begin
        in_ready     = out_ready && (state_reg != DRAIN);
        acc          = in_valid && in_ready;
        state_next   = state_reg;
        mode_next    = mode_reg;
        overrun_next = overrun_reg;
        shift_en     = 1'b0;
        flush        = 1'b0;
        emit         = 1'b0;
        err_next     = 1'b0;
        restart      = 1'b0;
        drain_done   = 1'b0;
        in_inc       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (acc && in_sop) begin
                    // SOP+EOP on one pixel is a runt frame: reject, stay idle.
                    if (in_eop) err_next = 1'b1;
                    else        restart  = 1'b1;
                end
            end
            FILL, RUN: begin
                if (acc) begin
                    if (in_sop) begin
                        // Unexpected SOP aborts the frame and starts a new one.
                        restart  = 1'b1;
                        err_next = 1'b1;
                    end else if (overrun_reg) begin
                        // Frame ran past TOTAL: swallow pixels until its EOP.
                        if (in_eop) begin
                            state_next   = DRAIN;
                            overrun_next = 1'b0;
                        end
                    end else begin
                        shift_en = 1'b1;
                        in_inc   = 1'b1;
                        emit     = (state_reg == RUN) || (in_cnt == DELAY_C);
                        if (in_eop) begin
                            state_next = DRAIN;
                            err_next   = !((state_reg == RUN) && in_term);
                        end else if ((state_reg == RUN) && in_term) begin
                            overrun_next = 1'b1;
                            err_next     = 1'b1;
                        end else if (emit) begin
                            state_next = RUN;
                        end
                    end
                end
            end
            DRAIN: begin
                flush    = 1'b1;
                shift_en = out_ready;
                emit     = out_ready;
                // Stop on the full-frame last pixel or after a full window.
                if (out_ready && (drain_term || out_term)) begin
                    drain_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (restart) begin
            state_next   = FILL;
            mode_next    = freq_flag;
            shift_en     = 1'b1;
            overrun_next = 1'b0;
        end
    end

    // in_cnt: pixels accepted in this frame (an SOP loads 1).
    pixel_counter #(.CNT_W(CNT_W), .TERMINAL(TOTAL - 1)) u_in_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_inc || restart),
        .clr   (restart),
        .count (in_cnt),
        .term  (in_term)
    );

    // out_cnt: outputs emitted; forced to 0 on abort and at end of drain.
    pixel_counter #(.CNT_W(CNT_W), .TERMINAL(TOTAL - 1)) u_out_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (emit && !drain_done),
        .clr   (restart || drain_done),
        .count (out_cnt),
        .term  (out_term)
    );

    // drain_cnt: flush shifts performed; only its terminal flag is consumed.
    pixel_counter #(.CNT_W(CNT_W), .TERMINAL(DELAY - 1)) u_drain_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   ((state_reg == DRAIN) && out_ready && !drain_done),
        .clr   (drain_done),
        .count (drain_cnt_unused),
        .term  (drain_term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            mode_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_sop_reg   <= 1'b0;
            out_eop_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            overrun_reg   <= overrun_next;
            frame_err_reg <= err_next;
            // Flags hold while downstream stalls; the last drain shift always
            // closes the packet, even for a truncated frame.
            if (out_ready) begin
                out_valid_reg <= emit;
                out_sop_reg   <= emit && (out_cnt == '0);
                out_eop_reg   <= emit && (out_term || drain_done);
            end
        end
    end

    assign mode_sel  = mode_reg;
    assign out_valid = out_valid_reg;
    assign out_sop   = out_sop_reg;
    assign out_eop   = out_eop_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_blur_frame_sequencer.sv
// Bench for blur_frame_sequencer on a reduced 8x4 frame (TOTAL 32, DELAY 19).
module tb_blur_frame_sequencer;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int TOTAL = W * H;
    localparam int DELAY = 2 * W + 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, freq_flag = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, shift_en, flush, mode_sel, out_valid, out_sop, out_eop;
    logic frame_err, busy;

    logic ready_rand = 1'b0;
    logic ready_force = 1'b1;

    int checks = 0;
    int errors = 0;

    blur_frame_sequencer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .freq_flag (freq_flag),
        .shift_en  (shift_en),
        .flush     (flush),
        .mode_sel  (mode_sel),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    // Downstream ready: forced value or 50% random, changed just after posedge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? ($urandom_range(1) == 1) : ready_force;
        end
    end

    // Output monitor, sampled on the falling edge.
    int   cyc = 0, xfers = 0, sops = 0, eops = 0, errs = 0, unstable = 0;
    int   frame_start = 0, last_len = 0, sop_acc_cyc = 0, first_valid_cyc = 0;
    logic prev_hold = 1'b0, prev_valid = 1'b0;
    logic [2:0] prev_flags = 3'b000;

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_hold  <= out_valid && !out_ready;
        prev_flags <= {out_valid, out_sop, out_eop};
        prev_valid <= out_valid;
        if (prev_hold && ({out_valid, out_sop, out_eop} != prev_flags)) unstable <= unstable + 1;
        if (frame_err) errs <= errs + 1;
        if (in_valid && in_ready && in_sop && !busy) sop_acc_cyc <= cyc;
        if (out_valid && !prev_valid) first_valid_cyc <= cyc;
        if (out_valid && out_ready) begin
            xfers <= xfers + 1;
            if (out_sop) begin
                sops        <= sops + 1;
                frame_start <= xfers;
            end
            if (out_eop) begin
                eops     <= eops + 1;
                last_len <= xfers - (out_sop ? xfers : frame_start) + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Present one pixel (called just after a posedge) and hold it until accepted.
    task automatic send_px(input logic sop, input logic eop, input logic ff, input int gap_pct);
        int wait_cyc = 0;
        for (int g = 0; g < 3; g++) begin
            if ($urandom_range(99) >= gap_pct) break;
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1; in_sop = sop; in_eop = eop; freq_flag = ff;
        @(negedge clk);
        while (!in_ready) begin
            wait_cyc++;
            if (wait_cyc > 500) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout waited=%0d cycles required=<500", wait_cyc);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic with_eop, input logic ff0,
                              input logic ff_rest, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            send_px(i == 0, with_eop && (i == len - 1), (i == 0) ? ff0 : ff_rest, gap_pct);
            if (i == 0) begin
                check("mode_at_sop", int'(mode_sel), int'(ff0));
                check("busy_after_sop", int'(busy), 1);
            end
            if (i == len - 1) check("mode_hold", int'(mode_sel), int'(ff0));
        end
    endtask

    // Wait for the drain to finish and the last output to leave.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy || out_valid) begin
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout busy=%0d out_valid=%0d required=0", busy, out_valid);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    int s_x, s_s, s_e, s_r, s_u;
    task automatic snap();
        s_x = xfers; s_s = sops; s_e = eops; s_r = errs; s_u = unstable;
    endtask

    task automatic frame_checks(input string tag, input int nx, input int ns,
                                input int ne, input int nerr, input int len);
        check({tag, "_xfers"}, xfers - s_x, nx);
        check({tag, "_sops"}, sops - s_s, ns);
        check({tag, "_eops"}, eops - s_e, ne);
        check({tag, "_frame_err"}, errs - s_r, nerr);
        check({tag, "_last_len"}, last_len, len);
        check({tag, "_unstable"}, unstable - s_u, 0);
    endtask

    typedef struct packed {
        logic vld, sop, eop, rdy, ff;
        logic e_rdy, e_shift, e_err, e_busy, e_mode;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // {valid, sop, eop, out_ready, freq_flag, in_ready, shift_en, frame_err, busy, mode_sel}
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // non-SOP discarded
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // runt
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // stalled SOP
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}; // SOP, blur
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // SOP not valid
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // SOP, bypass
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // all low
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // stray EOP

        // Reset state.
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_in_ready", int'(in_ready), int'(out_ready));
        @(negedge clk);
        reset = 1'b0;

        // Single-cycle IDLE behaviour, one reset per vector.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            reset = 1'b1;
            #1;
            reset = 1'b0;
            ready_rand  = 1'b0;
            ready_force = vecs[v].rdy;
            @(posedge clk);
            #2;
            in_valid = vecs[v].vld; in_sop = vecs[v].sop; in_eop = vecs[v].eop;
            freq_flag = vecs[v].ff;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", v), int'(in_ready), int'(vecs[v].e_rdy));
            check($sformatf("vec%0d_shift_en", v), int'(shift_en), int'(vecs[v].e_shift));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_frame_err", v), int'(frame_err), int'(vecs[v].e_err));
            check($sformatf("vec%0d_busy", v), int'(busy), int'(vecs[v].e_busy));
            check($sformatf("vec%0d_mode_sel", v), int'(mode_sel), int'(vecs[v].e_mode));
            $display("vec%0d applied", v);
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        ready_force = 1'b1;
        @(posedge clk);
        #1;

        // 1: clean gapless frame.
        snap();
        send_frame(TOTAL, 1'b1, 1'b0, 1'b0, 0);
        wait_idle();
        frame_checks("clean", TOTAL, 1, 1, 0, TOTAL);
        check("first_out_latency", first_valid_cyc - sop_acc_cyc, DELAY + 1);
        $display("frame clean done");

        // 2: blur latched at SOP, request dropped mid-frame.
        snap();
        send_frame(TOTAL, 1'b1, 1'b1, 1'b0, 0);
        wait_idle();
        frame_checks("mode", TOTAL, 1, 1, 0, TOTAL);
        check("mode_after_frame", int'(mode_sel), 1);
        $display("frame mode done");

        // 3: random input gaps and downstream stalls; mode returns to bypass.
        ready_rand = 1'b1;
        snap();
        send_frame(TOTAL, 1'b1, 1'b0, 1'b1, 50);
        wait_idle();
        frame_checks("stall", TOTAL, 1, 1, 0, TOTAL);
        ready_rand = 1'b0;
        $display("frame stall done");

        // 4: SOP injected at pixel 25 (RUN): 6 outputs of the aborted frame.
        snap();
        send_frame(25, 1'b0, 1'b0, 1'b0, 0);
        send_frame(TOTAL, 1'b1, 1'b0, 1'b0, 0);
        wait_idle();
        frame_checks("abort", TOTAL + 25 - DELAY, 2, 1, 1, TOTAL);
        $display("frame abort done");

        // 5: EOP at pixel 10 (FILL): full-window drain closed by out_eop.
        snap();
        send_frame(11, 1'b1, 1'b0, 1'b0, 0);
        wait_idle();
        frame_checks("early_eop", DELAY, 1, 1, 1, DELAY);
        check("early_eop_busy", int'(busy), 0);
        snap();
        send_frame(TOTAL, 1'b1, 1'b0, 1'b0, 0);
        wait_idle();
        frame_checks("post_early", TOTAL, 1, 1, 0, TOTAL);
        $display("frame early_eop done");

        // 7: three extra pixels past TOTAL are discarded.
        snap();
        send_frame(TOTAL + 3, 1'b1, 1'b0, 1'b0, 0);
        wait_idle();
        frame_checks("overrun", TOTAL, 1, 1, 1, TOTAL);
        $display("frame overrun done");

        // 6: asynchronous reset in DRAIN.
        send_frame(TOTAL, 1'b1, 1'b1, 1'b1, 0);
        repeat (3) @(posedge clk);
        #3;
        check("drain_out_valid", int'(out_valid), 1);
        check("drain_busy", int'(busy), 1);
        check("drain_shift_en", int'(shift_en), 1);
        reset = 1'b1;
        #1;
        check("rst_drain_out_valid", int'(out_valid), 0);
        check("rst_drain_busy", int'(busy), 0);
        check("rst_drain_shift_en", int'(shift_en), 0);
        check("rst_drain_mode", int'(mode_sel), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        snap();
        send_frame(TOTAL, 1'b1, 1'b0, 1'b0, 0);
        wait_idle();
        frame_checks("post_reset", TOTAL, 1, 1, 0, TOTAL);
        $display("frame post_reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
